inst_fetch: RTL and testbench



---
 rtl/inst_fetch.sv | 56 +++++
 tb/tb_inst_fetch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: MIPS fetch stage driving a synchronous-read ROM, with one read in flight and a 2-entry {pc,inst} queue
module inst_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [29:0] out_pc,
  output logic [31:0] out_inst
);
  logic [29:0] pc, inflight_pc;
  logic        inflight, pop, push, issue;
  logic [1:0]  count, cnt_ap;
  logic [29:0] q_pc [2];
  logic [31:0] q_inst [2];
  assign imem_addr = redirect_valid ? redirect_pc : pc;
  assign out_valid = count != 2'd0;
  assign out_pc    = q_pc[0];
  assign out_inst  = q_inst[0];
  assign pop       = out_valid & out_ready;
  assign push      = inflight & ~redirect_valid;
  assign cnt_ap    = count - {1'b0, pop};
  // queued + in-flight words after this pop must leave room for the word being issued
  assign issue     = redirect_valid | (({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      q_pc        <= '{default: '0};
      q_inst      <= '{default: '0};
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= imem_addr;
        pc          <= imem_addr + 30'd1;
      end
      count <= redirect_valid ? 2'd0 : cnt_ap + {1'b0, push};
      if (pop) begin
        q_pc[0]   <= q_pc[1];
        q_inst[0] <= q_inst[1];
      end
      if (push) begin
        q_pc[cnt_ap[0]]   <= inflight_pc;
        q_inst[cnt_ap[0]] <= imem_inst;
      end
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && count == 2'd2));
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard plus table-driven redirect vectors for inst_fetch
module tb_inst_fetch;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [29:0] imem_addr, redirect_pc, out_pc;
  logic [31:0] imem_inst, out_inst;
  logic        redirect_valid, out_valid, out_ready;
  int checks = 0, errors = 0;

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [29:0] a);
    case (a)
      30'h0:   return 32'h3c1d1000;
      30'h1:   return 32'h0c00006d;
      30'h3:   return 32'h27bdffd8;
      30'h6d:  return 32'h27bdffd0;
      30'h6e:  return 32'hafbf002c;
      default: return {a, 2'b00} ^ 32'h8000_0003;
    endcase
  endfunction

  always @(posedge clk) imem_inst <= rom_word(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [29:0] exp_q [$];
  logic [29:0] prev_pc, e;
  logic [31:0] prev_inst;
  logic        prev_stall = 1'b0;

  task automatic reload(input logic [29:0] s);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(s + 30'(i));
  endtask

  // every delivered word must be the next one of the current stream
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_valid", out_valid, 0);
      reload(30'h0);
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_pc", out_pc, prev_pc);
        chk("hold_inst", out_inst, prev_inst);
      end
      prev_stall = out_valid && !out_ready && !redirect_valid;
      prev_pc    = out_pc;
      prev_inst  = out_inst;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got pc %h expected no transfer", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", out_pc, e);
          chk("sb_inst", out_inst, rom_word(e));
        end
      end
      if (redirect_valid) reload(redirect_pc);
    end
  end

  task automatic wait_head(input logic [29:0] p);
    int n = 0;
    while (!(out_valid && out_pc == p) && n < 50) begin
      tick();
      n++;
    end
    chk("wait_head", {out_valid, out_pc}, {1'b1, p});
  endtask

  typedef struct {
    logic [29:0] rpc;
    logic [31:0] i0;
    logic [29:0] pc1;
    logic [31:0] i1;
  } redir_t;
  redir_t tbl [4];

  initial begin
    tbl[0] = '{30'h6d, 32'h27bdffd0, 30'h6e, 32'hafbf002c};
    tbl[1] = '{30'h3FFF_FFFF, 32'h7FFF_FFFF, 30'h0, 32'h3c1d1000};
    tbl[2] = '{30'h100, 32'h8000_0403, 30'h101, 32'h8000_0407};
    tbl[3] = '{30'h2, 32'h8000_000B, 30'h3, 32'h27bdffd8};
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_inst", out_inst, 0);
    chk("rst_addr", imem_addr, 0);
    redirect_valid = 1'b1;
    redirect_pc = 30'h55;
    #1 chk("addr_mux", imem_addr, 30'h55);
    redirect_valid = 1'b0;
    redirect_pc = '0;
    rst_n = 1'b1;
    tick();
    chk("first_c1_valid", out_valid, 0);
    tick();
    chk("first_valid", out_valid, 1);
    chk("first_pc", out_pc, 0);
    chk("first_inst", out_inst, 32'h3c1d1000);
    tick();
    chk("second_pc", out_pc, 1);
    chk("second_inst", out_inst, 32'h0c00006d);
    wait_head(30'h3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_pc", out_pc, 30'h3);
      chk("stall_inst", out_inst, 32'h27bdffd8);
      chk("stall_addr", imem_addr, 30'h5);
    end
    out_ready = 1'b1;
    for (int i = 4; i < 7; i++) begin
      tick();
      chk("release_valid", out_valid, 1);
      chk("release_pc", out_pc, 30'(i));
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("no_bubble", out_valid, 1);
    end
    foreach (tbl[k]) begin
      redirect_valid = 1'b1;
      redirect_pc = tbl[k].rpc;
      #1 chk("redir_addr", imem_addr, tbl[k].rpc);
      tick();
      redirect_valid = 1'b0;
      chk("redir_bubble", out_valid, 0);
      tick();
      chk("redir_valid", out_valid, 1);
      chk("redir_pc0", out_pc, tbl[k].rpc);
      chk("redir_inst0", out_inst, tbl[k].i0);
      tick();
      chk("redir_pc1", out_pc, tbl[k].pc1);
      chk("redir_inst1", out_inst, tbl[k].i1);
      repeat (3) tick();
    end
    out_ready = 1'b0;
    repeat (3) tick();
    chk("full_valid", out_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc = 30'h40;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    chk("full_redir_bubble", out_valid, 0);
    tick();
    chk("full_redir_pc", out_pc, 30'h40);
    tick();
    chk("full_redir_pc1", out_pc, 30'h41);
    redirect_valid = 1'b1;
    redirect_pc = 30'h80;
    tick();
    redirect_valid = 1'b0;
    chk("pop_redir_bubble", out_valid, 0);
    tick();
    chk("pop_redir_pc", out_pc, 30'h80);
    redirect_valid = 1'b1;
    redirect_pc = 30'h200;
    tick();
    redirect_pc = 30'h300;
    tick();
    redirect_valid = 1'b0;
    chk("b2b_bubble", out_valid, 0);
    tick();
    chk("b2b_pc", out_pc, 30'h300);
    chk("b2b_inst", out_inst, 32'h8000_0C03);
    tick();
    chk("b2b_inst1", out_inst, 32'h8000_0C07);
    out_ready = 1'b0;
    repeat (3) tick();
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_pc", out_pc, 0);
    chk("async_inst", out_inst, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("restart_c1_valid", out_valid, 0);
    tick();
    chk("restart_valid", out_valid, 1);
    chk("restart_pc", out_pc, 0);
    chk("restart_inst", out_inst, 32'h3c1d1000);
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
